// File: rtl/cache_bus_pkg.sv
// Shared types and constants for the L1 cache <-> memory bus arbiter.
package cache_bus_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      BURST = 2'd2
   } arb_state_e;

   localparam int WORDSIZE_DEF = 64;
   localparam int TAGW_DEF     = 13;
   localparam int BEATS_DEF    = 8;

   localparam int CLIENT_I = 0;
   localparam int CLIENT_D = 1;

   // MSB of a request tag marks a read; every fill issued here is a read.
   localparam int READ_TAG_BIT = TAGW_DEF - 1;

   function automatic logic [1:0] client_onehot(input logic client);
      return client ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/cache_mem_arbiter_rr.sv
// Two-way round-robin pick: a sole requester wins, on a tie the client
// that was not granted last time wins.
module rr_arbiter2
   import cache_bus_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] grant,
   output logic       win
);

   // Winner selection and one-hot grant.
   always_comb begin
      win   = 1'b0;
      grant = 2'b00;
      if (req == 2'b11) begin
         win = ~last;
      end else if (req[CLIENT_D]) begin
         win = 1'b1;
      end
      if (|req) begin
         grant = client_onehot(win);
      end
   end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates the I-cache and D-cache onto one memory bus: one line-fill
// request at a time, response burst steered back to the owning cache.
module cache_mem_arbiter
   import cache_bus_pkg::*;
#(
   parameter int WORDSIZE = WORDSIZE_DEF,
   parameter int TAGW     = TAGW_DEF,
   parameter int BEATS    = BEATS_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [1:0]               c_reqcyc,
   input  logic [1:0][WORDSIZE-1:0] c_req,
   input  logic [1:0][TAGW-1:0]     c_reqtag,
   output logic [1:0]               c_reqack,
   output logic [1:0]               c_respcyc,
   output logic [WORDSIZE-1:0]      c_resp,
   output logic [TAGW-1:0]          c_resptag,
   input  logic [1:0]               c_respack,
   output logic                     bus_reqcyc,
   output logic [WORDSIZE-1:0]      bus_req,
   output logic [TAGW-1:0]          bus_reqtag,
   input  logic                     bus_reqack,
   input  logic                     bus_respcyc,
   input  logic [WORDSIZE-1:0]      bus_resp,
   input  logic [TAGW-1:0]          bus_resptag,
   output logic                     bus_respack
);

   localparam int CNT_W = $clog2(BEATS) + 1;

   arb_state_e          state_q, state_d;
   logic                owner_q, owner_d;
   logic                last_grant_q, last_grant_d;
   logic [CNT_W-1:0]    beat_q, beat_d;
   logic [1:0]          c_reqack_q, c_reqack_d;
   logic                bus_reqcyc_q, bus_reqcyc_d;
   logic [WORDSIZE-1:0] bus_req_q, bus_req_d;
   logic [TAGW-1:0]     bus_reqtag_q, bus_reqtag_d;

   logic [1:0]          arb_grant;
   logic                arb_win;
   logic                active;
   logic                beat_fire;

   rr_arbiter2 u_rr (
      .req   (c_reqcyc),
      .last  (last_grant_q),
      .grant (arb_grant),
      .win   (arb_win)
   );

   assign active = (state_q != IDLE);

   // Response steering: bus beats go straight to the owner, nothing in IDLE.
   always_comb begin
      c_respcyc   = 2'b00;
      c_resp      = '0;
      c_resptag   = '0;
      bus_respack = 1'b0;
      if (active) begin
         c_respcyc[owner_q] = bus_respcyc;
         c_resp             = bus_resp;
         c_resptag          = bus_resptag;
         bus_respack        = c_respack[owner_q];
      end
   end

   assign beat_fire = bus_respcyc & bus_respack;

   // Next-state: grant in IDLE, hold the bus request until accepted, count beats.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      beat_d       = beat_q;
      c_reqack_d   = 2'b00;
      bus_reqcyc_d = bus_reqcyc_q;
      bus_req_d    = bus_req_q;
      bus_reqtag_d = bus_reqtag_q;
      case (state_q)
         IDLE: begin
            if (|c_reqcyc) begin
               c_reqack_d   = arb_grant;
               bus_req_d    = c_req[arb_win];
               bus_reqtag_d = c_reqtag[arb_win];
               bus_reqcyc_d = 1'b1;
               owner_d      = arb_win;
               last_grant_d = arb_win;
               beat_d       = '0;
               state_d      = REQ;
            end
         end
         REQ: begin
            if (bus_reqack) begin
               bus_reqcyc_d = 1'b0;
               state_d      = BURST;
            end
         end
         default: ;
      endcase
      // A beat can arrive while still in REQ; the final beat ends the fill either way.
      if (active && beat_fire) begin
         beat_d = beat_q + 1'b1;
         if (beat_q == CNT_W'(BEATS - 1)) begin
            state_d      = IDLE;
            bus_reqcyc_d = 1'b0;
         end
      end
   end

   // State and registered outputs, synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= IDLE;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         beat_q       <= '0;
         c_reqack_q   <= 2'b00;
         bus_reqcyc_q <= 1'b0;
         bus_req_q    <= '0;
         bus_reqtag_q <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         beat_q       <= beat_d;
         c_reqack_q   <= c_reqack_d;
         bus_reqcyc_q <= bus_reqcyc_d;
         bus_req_q    <= bus_req_d;
         bus_reqtag_q <= bus_reqtag_d;
      end
   end

   assign c_reqack   = c_reqack_q;
   assign bus_reqcyc = bus_reqcyc_q;
   assign bus_req    = bus_req_q;
   assign bus_reqtag = bus_reqtag_q;

endmodule
